// File: rtl/cp2_ctrl_pkg.sv
// rtl/cp2_ctrl_pkg.sv - shared state encoding, default parameters and ratio-slice helper for cp2_run_ctrl
package cp2_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_DONE = 2'd3
    } cp2_state_e;

    localparam int DEF_RST_HOLD = 2;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_CNT_W    = 16;

    // Packed ratio buses are widened to this many bits before slicing.
    localparam int RATIO_VEC_W  = 256;

    function automatic logic [RATIO_VEC_W-1:0] ratio_slice(
        input logic [RATIO_VEC_W-1:0] vec,
        input int                     ch,
        input int                     w
    );
        logic [RATIO_VEC_W-1:0] mask;
        mask = (RATIO_VEC_W'(1) << w) - RATIO_VEC_W'(1);
        return (vec >> (ch * w)) & mask;
    endfunction

endpackage

// File: rtl/cp2en_div_ch.sv
// rtl/cp2en_div_ch.sv - one divided clock-enable channel: phase counter, shadow ratio and enable decode
module cp2en_div_ch
    import cp2_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             run,
    input  logic             hold,
    input  logic             clr,
    input  logic [DIV_W-1:0] ratio,
    output logic             en
);

    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;

    // Shadow tracks the live ratio during HOLD so RUN starts with the value present on entry.
    always_comb begin
        phase_d  = phase_q;
        shadow_d = shadow_q;
        if (clr) begin
            phase_d = '0;
        end else if (hold) begin
            phase_d  = '0;
            shadow_d = ratio;
        end else if (run) begin
            if (phase_q == shadow_q) begin
                phase_d  = '0;
                shadow_d = ratio;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            phase_q  <= '0;
            shadow_q <= '0;
        end else begin
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
        end
    end

    assign en = run && (phase_q == '0);

endmodule

// File: rtl/cp2_run_ctrl.sv
// rtl/cp2_run_ctrl.sv - reset-hold / run / halt / done sequencer driving core reset and divided cp2 enables
module cp2_run_ctrl
    import cp2_ctrl_pkg::*;
#(
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    cp2,
    input  logic                    ireset,
    input  logic                    ext_rst_req,
    input  logic                    halt_req,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [CNT_W-1:0]        run_limit,
    output logic                    core_rst_n,
    output logic [NUM_CH-1:0]       cp2en,
    output logic [CNT_W-1:0]        run_cnt,
    output logic                    done,
    output logic [1:0]              state
);

    localparam int                 HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    cp2_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              done_q, done_d;
    logic              inc;
    logic              in_run, in_hold;
    logic [RATIO_VEC_W-1:0] div_vec;

    assign in_run  = (state_q == ST_RUN);
    assign in_hold = (state_q == ST_HOLD);
    assign div_vec = RATIO_VEC_W'(div_ratio);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cp2en_div_ch #(.DIV_W(DIV_W)) u_ch (
            .cp2    (cp2),
            .ireset (ireset),
            .run    (in_run),
            .hold   (in_hold),
            .clr    (ext_rst_req),
            .ratio  (DIV_W'(ratio_slice(div_vec, i, DIV_W))),
            .en     (cp2en[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        inc        = cp2en[0] && (run_cnt_q != '1);
        run_cnt_d  = inc ? run_cnt_q + 1'b1 : run_cnt_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Compare against the live limit so a mid-run change applies immediately.
                if ((run_limit != '0) && inc && (run_cnt_d == run_limit)) begin
                    state_d = ST_DONE;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (ext_rst_req) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            run_cnt_d  = '0;
        end

        core_rst_n_d = (state_d != ST_HOLD);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            run_cnt_q    <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            run_cnt_q    <= run_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign run_cnt    = run_cnt_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule
